// File: rtl/audio_pkg.sv
// Shared constants and types for the I2S microphone receiver.
package audio_pkg;

    localparam logic MODE_STD   = 1'b0;
    localparam logic MODE_ULTRA = 1'b1;

    localparam logic WS_LEFT  = 1'b0;
    localparam logic WS_RIGHT = 1'b1;

    localparam int HALF_STD_DEF    = 6;
    localparam int HALF_ULTRA_DEF  = 3;
    localparam int SLOT_BITS_DEF   = 32;
    localparam int SAMPLE_BITS_DEF = 24;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } i2s_state_e;

endpackage

// File: rtl/i2s_clk_gen.sv
// SCK/WS generator: divides clk into the bit clock, counts bits within a
// stereo frame and flags the rising/falling SCK edges for the capture logic.
module i2s_clk_gen
    import audio_pkg::*;
#(
    parameter int SLOT_BITS  = SLOT_BITS_DEF,
    parameter int HALF_STD   = HALF_STD_DEF,
    parameter int HALF_ULTRA = HALF_ULTRA_DEF,
    parameter int BIT_W      = $clog2(2 * SLOT_BITS)
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             enable_i,
    input  logic             mode_i,
    output logic             sck_o,
    output logic             ws_o,
    output logic             rise_evt_o,
    output logic             fall_evt_o,
    output logic             frame_start_o,
    output logic [BIT_W-1:0] bit_cnt_o
);

    localparam int HALF_MAX = (HALF_STD > HALF_ULTRA) ? HALF_STD : HALF_ULTRA;
    localparam int DIV_W    = $clog2(HALF_MAX + 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(2 * SLOT_BITS - 1);
    localparam logic [BIT_W-1:0] SLOT_LIM = BIT_W'(SLOT_BITS);

    i2s_state_e       state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d, div_last;
    logic [BIT_W-1:0] bit_q, bit_d, bit_nxt;
    logic             sck_q, sck_d;
    logic             ws_q, ws_d;
    logic             half_sel_q, half_sel_d;

    assign div_last = (half_sel_q == MODE_ULTRA) ? DIV_W'(HALF_ULTRA - 1)
                                                 : DIV_W'(HALF_STD - 1);
    assign bit_nxt  = (bit_q == BIT_LAST) ? '0 : bit_q + 1'b1;

    always_comb begin
        state_d       = state_q;
        div_d         = div_q;
        bit_d         = bit_q;
        sck_d         = sck_q;
        ws_d          = ws_q;
        half_sel_d    = half_sel_q;
        rise_evt_o    = 1'b0;
        fall_evt_o    = 1'b0;
        frame_start_o = 1'b0;
        case (state_q)
            ST_IDLE: begin
                div_d = '0;
                bit_d = '0;
                sck_d = 1'b0;
                ws_d  = WS_LEFT;
                if (enable_i) begin
                    state_d    = ST_RUN;
                    half_sel_d = mode_i;
                end
            end
            ST_RUN: begin
                if (!enable_i) begin
                    // Partial frame is abandoned; the next run restarts at bit 0.
                    state_d = ST_IDLE;
                    div_d   = '0;
                    bit_d   = '0;
                    sck_d   = 1'b0;
                    ws_d    = WS_LEFT;
                end else if (div_q == div_last) begin
                    div_d = '0;
                    sck_d = ~sck_q;
                    if (!sck_q) begin
                        rise_evt_o = 1'b1;
                    end else begin
                        fall_evt_o = 1'b1;
                        bit_d      = bit_nxt;
                        ws_d       = (bit_nxt >= SLOT_LIM) ? WS_RIGHT : WS_LEFT;
                        if (bit_q == BIT_LAST) begin
                            // Speed changes only land on whole frames.
                            frame_start_o = 1'b1;
                            half_sel_d    = mode_i;
                        end
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= ST_IDLE;
            div_q      <= '0;
            bit_q      <= '0;
            sck_q      <= 1'b0;
            ws_q       <= WS_LEFT;
            half_sel_q <= MODE_STD;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            bit_q      <= bit_d;
            sck_q      <= sck_d;
            ws_q       <= ws_d;
            half_sel_q <= half_sel_d;
        end
    end

    assign sck_o     = sck_q;
    assign ws_o      = ws_q;
    assign bit_cnt_o = bit_q;

endmodule

// File: rtl/i2s_mic_rx.sv
// I2S master receiver for MEMS microphones: drives SCK/WS, deserialises the
// left/right slots and hands out one stereo frame per valid/ready handshake.
module i2s_mic_rx
    import audio_pkg::*;
#(
    parameter int SLOT_BITS   = SLOT_BITS_DEF,
    parameter int SAMPLE_BITS = SAMPLE_BITS_DEF,
    parameter int CHANNELS    = 2,
    parameter int HALF_STD    = HALF_STD_DEF,
    parameter int HALF_ULTRA  = HALF_ULTRA_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   mode,
    input  logic                   sd,
    output logic                   sck,
    output logic                   ws,
    output logic [SAMPLE_BITS-1:0] left_data,
    output logic [SAMPLE_BITS-1:0] right_data,
    output logic                   valid,
    input  logic                   ready,
    output logic                   overrun,
    input  logic                   clear_overrun
);

    localparam int BIT_W = $clog2(2 * SLOT_BITS);
    localparam logic [BIT_W-1:0] SLOT_LIM = BIT_W'(SLOT_BITS);
    localparam logic [BIT_W-1:0] POS_LAST = BIT_W'(SAMPLE_BITS);
    localparam logic LAST_SLOT = (CHANNELS == 2) ? WS_RIGHT : WS_LEFT;

    logic             rise_evt, fall_evt, frame_start;
    logic [BIT_W-1:0] bit_cnt, pos;
    logic             slot_r, cap_en, done, ovr_set;

    logic [CHANNELS-1:0][SAMPLE_BITS-1:0] sh_q, sh_d;
    logic [SAMPLE_BITS-1:0] left_q, left_d, right_q, right_d;
    logic                   valid_q, valid_d, ovr_q, ovr_d;

    i2s_clk_gen #(
        .SLOT_BITS  (SLOT_BITS),
        .HALF_STD   (HALF_STD),
        .HALF_ULTRA (HALF_ULTRA),
        .BIT_W      (BIT_W)
    ) u_clk_gen (
        .clk_i         (clk),
        .reset_i       (reset),
        .enable_i      (enable),
        .mode_i        (mode),
        .sck_o         (sck),
        .ws_o          (ws),
        .rise_evt_o    (rise_evt),
        .fall_evt_o    (fall_evt),
        .frame_start_o (frame_start),
        .bit_cnt_o     (bit_cnt)
    );

    // Slot position; position 0 is the I2S delay bit and is never captured.
    assign slot_r = (bit_cnt >= SLOT_LIM);
    assign pos    = slot_r ? bit_cnt - SLOT_LIM : bit_cnt;
    assign cap_en = rise_evt && (pos != '0) && (pos <= POS_LAST);
    assign done   = cap_en && (pos == POS_LAST) && (slot_r == LAST_SLOT);

    always_comb begin
        sh_d = sh_q;
        for (int c = 0; c < CHANNELS; c++) begin
            if (fall_evt && frame_start) begin
                sh_d[c] = '0;
            end else if (cap_en && (slot_r == (c == 1))) begin
                sh_d[c] = SAMPLE_BITS'({sh_q[c], sd});
            end
        end
    end

    always_comb begin
        valid_d = valid_q;
        left_d  = left_q;
        right_d = right_q;
        ovr_set = 1'b0;
        if (done) begin
            if (!valid_q || ready) begin
                valid_d = 1'b1;
                left_d  = sh_d[0];
                right_d = (CHANNELS == 2) ? sh_d[CHANNELS-1] : '0;
            end else begin
                ovr_set = 1'b1;
            end
        end else if (valid_q && ready) begin
            valid_d = 1'b0;
        end
        if (ovr_set) begin
            ovr_d = 1'b1;
        end else if (clear_overrun) begin
            ovr_d = 1'b0;
        end else begin
            ovr_d = ovr_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sh_q    <= '0;
            left_q  <= '0;
            right_q <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            sh_q    <= sh_d;
            left_q  <= left_d;
            right_q <= right_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
        end
    end

    assign left_data  = left_q;
    assign right_data = right_q;
    assign valid      = valid_q;
    assign overrun    = ovr_q;

endmodule
